// File: rtl/freq_gate_ctrl_if.sv
// freq_gate_ctrl_if -- signal bundle between the gate controller and the
// counter / timebase datapath of the frequency meter.
//   master : the controller (freq_gate_ctrl). Samples tick, auto_en,
//            range_sw, cnt_ovf, th_digit; drives w_enable, clear, save,
//            range, out_range, busy.
//   slave  : the datapath side, mirror image of master.
interface freq_gate_ctrl_if;
  logic       tick;       // one-cycle timebase pulse
  logic       auto_en;    // 1 = auto-ranging
  logic       range_sw;   // manual range (0 = x1, 1 = /10)
  logic       cnt_ovf;    // counter passed 9999 this gate
  logic [3:0] th_digit;   // live thousands digit
  logic       w_enable;   // counter count-enable
  logic       clear;      // one-cycle counter clear
  logic       save;       // one-cycle display latch strobe
  logic       range;      // active prescale select
  logic       out_range;  // over-range indicator
  logic       busy;       // controller not idle

  modport master (
    input  tick, auto_en, range_sw, cnt_ovf, th_digit,
    output w_enable, clear, save, range, out_range, busy
  );

  modport slave (
    output tick, auto_en, range_sw, cnt_ovf, th_digit,
    input  w_enable, clear, save, range, out_range, busy
  );
endinterface

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl -- gate / range controller for a 4-digit BCD frequency meter.
// Opens a counting gate of GATE_TICKS timebase ticks, then evaluates the
// result: auto-ranges between x1 and /10 prescale (re-measuring after a
// discarded settle window when the range moves) or latches the count into
// the display with save.
// Ports:
//   sys_clk  : clock, rising edge
//   reset    : synchronous, active-high
//   bus      : freq_gate_ctrl_if.master (tick/auto_en/range_sw/cnt_ovf/
//              th_digit in; w_enable/clear/save/range/out_range/busy out)
// All outputs are registered. Strobes are produced from the current state,
// so clear appears the cycle after CLR and w_enable the cycle after the
// GATE cycle that requested it; this staggering keeps save, clear and
// w_enable mutually exclusive.
module freq_gate_ctrl #(
  parameter int GATE_TICKS = 1  // ticks per gate window, 1..15
) (
  input  logic             sys_clk,
  input  logic             reset,
  freq_gate_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_GATE,
    S_EVAL,
    S_SETTLE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(GATE_TICKS - 1);

  state_t     state, state_nx;
  logic [3:0] tcnt, tcnt_nx;
  logic       range_q, range_nx;
  logic       ovr_q, ovr_nx;
  logic       wen_q, wen_nx;
  logic       clr_q, clr_nx;
  logic       save_q, save_nx;
  logic       busy_q;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tcnt    <= '0;
      range_q <= 1'b0;
      ovr_q   <= 1'b0;
      wen_q   <= 1'b0;
      clr_q   <= 1'b0;
      save_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      tcnt    <= tcnt_nx;
      range_q <= range_nx;
      ovr_q   <= ovr_nx;
      wen_q   <= wen_nx;
      clr_q   <= clr_nx;
      save_q  <= save_nx;
      busy_q  <= (state_nx != S_IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    range_nx = range_q;
    ovr_nx   = ovr_q;
    wen_nx   = 1'b0;
    clr_nx   = 1'b0;
    save_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.tick) state_nx = S_CLR;
      end
      S_CLR: begin
        // A tick landing here is deliberately dropped.
        clr_nx   = 1'b1;
        tcnt_nx  = '0;
        state_nx = S_GATE;
      end
      S_GATE: begin
        wen_nx = 1'b1;
        if (bus.tick) begin
          if (tcnt == LAST_IDX) begin
            wen_nx   = 1'b0;  // close the gate right after the last tick
            state_nx = S_EVAL;
          end else begin
            tcnt_nx = tcnt + 4'd1;
          end
        end
      end
      S_EVAL: begin
        state_nx = S_CLR;
        if (!bus.auto_en) begin
          range_nx = bus.range_sw;
          ovr_nx   = bus.cnt_ovf;
          save_nx  = 1'b1;
        end else if (bus.cnt_ovf && !range_q) begin
          range_nx = 1'b1;        // up-range, re-measure after settling
          state_nx = S_SETTLE;
        end else if (bus.cnt_ovf) begin
          ovr_nx  = 1'b1;         // already on the top range
          save_nx = 1'b1;
        end else if (range_q && bus.th_digit == 4'd0) begin
          range_nx = 1'b0;        // count < 1000 on /10: go back to x1
          state_nx = S_SETTLE;
        end else begin
          ovr_nx  = 1'b0;
          save_nx = 1'b1;
        end
      end
      S_SETTLE: begin
        if (bus.tick) state_nx = S_CLR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.w_enable  = wen_q;
  assign bus.clear     = clr_q;
  assign bus.save      = save_q;
  assign bus.range     = range_q;
  assign bus.out_range = ovr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: two instances (GATE_TICKS=1 and 3) share one
// stimulus stream; a tick-level reference model predicts save/clear
// pulses, range, out_range, w_enable and busy per tick period.
module tb_freq_gate_ctrl;
  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, auto_en = 1'b1, range_sw = 1'b0, cnt_ovf = 1'b0;
  logic [3:0] th_digit = 4'd5;

  always #5 sys_clk = ~sys_clk;

  freq_gate_ctrl_if if1 ();
  freq_gate_ctrl_if if3 ();

  assign if1.tick = tick;     assign if3.tick = tick;
  assign if1.auto_en = auto_en;   assign if3.auto_en = auto_en;
  assign if1.range_sw = range_sw; assign if3.range_sw = range_sw;
  assign if1.cnt_ovf = cnt_ovf;   assign if3.cnt_ovf = cnt_ovf;
  assign if1.th_digit = th_digit; assign if3.th_digit = th_digit;

  freq_gate_ctrl #(.GATE_TICKS(1)) u_dut1 (.sys_clk(sys_clk), .reset(reset), .bus(if1.master));
  freq_gate_ctrl #(.GATE_TICKS(3)) u_dut3 (.sys_clk(sys_clk), .reset(reset), .bus(if3.master));

  logic [1:0] w_en, clr, sv, rng, ovr, bsy;
  assign w_en = {if3.w_enable, if1.w_enable};
  assign clr  = {if3.clear, if1.clear};
  assign sv   = {if3.save, if1.save};
  assign rng  = {if3.range, if1.range};
  assign ovr  = {if3.out_range, if1.out_range};
  assign bsy  = {if3.busy, if1.busy};

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // pulse monitor + strobe exclusivity assertion
  int sv_cnt [2] = '{0, 0};
  int cl_cnt [2] = '{0, 0};
  int sv_cyc [2] = '{0, 0};
  int ovl_err = 0;
  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sv[i]) begin sv_cnt[i]++; sv_cyc[i] = cyc; end
      if (clr[i]) cl_cnt[i]++;
      assert (!((sv[i] && clr[i]) || (sv[i] && w_en[i]) || (clr[i] && w_en[i])))
      else begin
        ovl_err++;
        $display("FAIL strobe_overlap inst%0d cyc=%0d save=%b clear=%b w_enable=%b required none together",
                 i, cyc, sv[i], clr[i], w_en[i]);
      end
    end
  end

  // tick-level reference model: phase 0=idle 1=gating 2=settle
  int   gt [2] = '{1, 3};
  int   ph [2], n [2];
  logic mr [2], mo [2], exp_sv [2], exp_cl [2];
  int   pass_cnt = 0, tot = 0;
  bit   rnd = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; n[i] = 0; mr[i] = 1'b0; mo[i] = 1'b0;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      exp_sv[i] = 1'b0; exp_cl[i] = 1'b0;
      if (ph[i] != 1) begin
        ph[i] = 1; n[i] = 0; exp_cl[i] = 1'b1;
      end else begin
        n[i]++;
        if (n[i] == gt[i]) begin
          n[i] = 0;
          if (!auto_en) begin
            mr[i] = range_sw; mo[i] = cnt_ovf; exp_sv[i] = 1'b1; exp_cl[i] = 1'b1;
          end else if (cnt_ovf && !mr[i]) begin
            mr[i] = 1'b1; ph[i] = 2;
          end else if (cnt_ovf) begin
            mo[i] = 1'b1; exp_sv[i] = 1'b1; exp_cl[i] = 1'b1;
          end else if (mr[i] && th_digit == 4'd0) begin
            mr[i] = 1'b0; ph[i] = 2;
          end else begin
            mo[i] = 1'b0; exp_sv[i] = 1'b1; exp_cl[i] = 1'b1;
          end
        end
      end
    end
  endtask

  // one tick followed by a period of p cycles, with checks
  task automatic tick_period(input int p);
    int sb [2], cb [2];
    int tc;
    @(posedge sys_clk); #1;
    for (int i = 0; i < 2; i++) begin sb[i] = sv_cnt[i]; cb[i] = cl_cnt[i]; end
    tc = cyc;
    tick = 1'b1;
    model_tick();
    @(posedge sys_clk); #1 tick = 1'b0;
    repeat (7) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      tot++;
      if ((sv_cnt[i] - sb[i]) !== int'(exp_sv[i]))
        $display("FAIL save_count inst%0d got %0d want %0d", i, sv_cnt[i] - sb[i], exp_sv[i]);
      else pass_cnt++;
      tot++;
      if ((cl_cnt[i] - cb[i]) !== int'(exp_cl[i]))
        $display("FAIL clear_count inst%0d got %0d want %0d", i, cl_cnt[i] - cb[i], exp_cl[i]);
      else pass_cnt++;
      tot++;
      if (rng[i] !== mr[i] || ovr[i] !== mo[i])
        $display("FAIL range inst%0d got range=%b out_range=%b want %b/%b", i, rng[i], ovr[i], mr[i], mo[i]);
      else pass_cnt++;
      if (exp_sv[i]) begin
        tot++;
        if (sv_cyc[i] - tc !== 2)
          $display("FAIL save_latency inst%0d got %0d want 2", i, sv_cyc[i] - tc);
        else pass_cnt++;
      end
    end
    repeat (p / 2 - 8) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      tot++;
      if (w_en[i] !== (ph[i] == 1) || bsy[i] !== (ph[i] != 0))
        $display("FAIL gate_level inst%0d got w_enable=%b busy=%b want %b/%b",
                 i, w_en[i], bsy[i], ph[i] == 1, ph[i] != 0);
      else pass_cnt++;
    end
    if (rnd) begin  // mid-gate changes only matter at the next evaluation
      auto_en  = ($urandom_range(0, 3) != 0);
      range_sw = 1'($urandom_range(0, 1));
      cnt_ovf  = 1'($urandom_range(0, 1));
      th_digit = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
    end
    repeat (p - p / 2) @(posedge sys_clk);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1 reset = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      tot++;
      if ({w_en[i], clr[i], sv[i], rng[i], ovr[i], bsy[i]} !== 6'b0)
        $display("FAIL reset_outputs inst%0d got %b want 000000",
                 i, {w_en[i], clr[i], sv[i], rng[i], ovr[i], bsy[i]});
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    auto_en = 1'b1; cnt_ovf = 1'b0; th_digit = 4'd5;
    repeat (4) tick_period(100);
  endtask

  task automatic test_uprange();
    cnt_ovf = 1'b1; tick_period(40);
    cnt_ovf = 1'b0; th_digit = 4'd3;
    repeat (4) tick_period(40);
  endtask

  task automatic test_downrange();
    cnt_ovf = 1'b0; th_digit = 4'd0;
    repeat (2) tick_period(40);
    cnt_ovf = 1'b1;
    repeat (6) tick_period(40);
  endtask

  task automatic test_manual();
    auto_en = 1'b0; range_sw = 1'b1; cnt_ovf = 1'b1; th_digit = 4'd0;
    repeat (6) tick_period(30);
    range_sw = 1'b0; cnt_ovf = 1'b0;
    repeat (3) tick_period(30);
  endtask

  task automatic test_reset_mid_gate();
    int sb [2];
    do_reset();
    auto_en = 1'b1; cnt_ovf = 1'b0; th_digit = 4'd5;
    repeat (3) tick_period(30);  // start + 2 counted ticks on the 3-tick gate
    @(posedge sys_clk); #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) sb[i] = sv_cnt[i];
    @(posedge sys_clk); #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      tot++;
      if ({w_en[i], clr[i], sv[i], rng[i], ovr[i], bsy[i]} !== 6'b0)
        $display("FAIL midgate_reset inst%0d got %b want 000000",
                 i, {w_en[i], clr[i], sv[i], rng[i], ovr[i], bsy[i]});
      else pass_cnt++;
    end
    repeat (10) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      tot++;
      if (sv_cnt[i] !== sb[i] || bsy[i] !== 1'b0)
        $display("FAIL midgate_idle inst%0d got saves=%0d busy=%b want 0/0", i, sv_cnt[i] - sb[i], bsy[i]);
      else pass_cnt++;
    end
    repeat (4) tick_period(30);
  endtask

  task automatic test_random();
    rnd = 1;
    repeat (80) tick_period($urandom_range(20, 40));
    rnd = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_uprange();
    test_downrange();
    test_manual();
    auto_en = 1'b1;
    test_reset_mid_gate();
    test_random();
    tot++;
    if (ovl_err !== 0) $display("FAIL strobe_exclusive got %0d overlaps want 0", ovl_err);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule

// File: doc/freq_gate_ctrl.md
FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

Interface
REQ-001 SHALL have parameter GATE_TICKS, default 1, the number of tick pulses per gate window (legal range 1..15).
REQ-002 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port tick, input, 1 bit: one-cycle timebase pulse (1 Hz nominal).
REQ-005 SHALL have port auto_en, input, 1 bit: 1 = auto-ranging, 0 = manual range from range_sw.
REQ-006 SHALL have port range_sw, input, 1 bit: manual range select (0 = x1, 1 = /10 prescale).
REQ-007 SHALL have port cnt_ovf, input, 1 bit: the BCD counter passed 9999 during the current gate.
REQ-008 SHALL have port th_digit, input, 4 bits: the live thousands BCD digit of the counter.
REQ-009 SHALL have port w_enable, output, 1 bit: counter count-enable.
REQ-010 SHALL have port clear, output, 1 bit: one-cycle counter clear.
REQ-011 SHALL have port save, output, 1 bit: one-cycle latch strobe to the display register.
REQ-012 SHALL have port range, output, 1 bit: active prescale select driven to the signal path.
REQ-013 SHALL have port out_range, output, 1 bit: over-range indicator.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, CLR, GATE, EVAL and SETTLE.
REQ-016 IDLE SHALL go to CLR on the first tick; all strobes are low in IDLE.
REQ-017 CLR SHALL assert clear for exactly one cycle, then go to GATE.
REQ-018 GATE SHALL hold w_enable=1 and count tick pulses in a 4-bit counter; the counter is zeroed on GATE entry.
REQ-019 On the GATE_TICKS-th tick, GATE SHALL deassert w_enable on the next cycle and go to EVAL; the gate length is therefore GATE_TICKS tick periods, and a tick arriving in the CLR cycle is ignored.
REQ-020 EVAL (one cycle, w_enable=0) SHALL decide as follows when auto_en=1:
 - cnt_ovf=1 and range=0: range<=1, no save, go SETTLE.
 - cnt_ovf=1 and range=1: out_range<=1, save=1, go CLR.
 - cnt_ovf=0, range=1 and th_digit==0: range<=0, no save, go SETTLE (down-range hysteresis, count <1000).
 - otherwise: out_range<=0, save=1, go CLR.
REQ-021 When auto_en=0, EVAL SHALL set range<=range_sw, set out_range<=cnt_ovf, pulse save, and go CLR.
REQ-022 SETTLE SHALL wait for one tick (the discarded settle window), then go CLR; save is never asserted there.
REQ-023 save and clear SHALL never be asserted in the same cycle, and neither SHALL be asserted while w_enable=1.
REQ-024 A range change SHALL occur only in EVAL; range is stable throughout CLR, GATE and SETTLE.
REQ-025 A change of auto_en or range_sw mid-gate SHALL take effect only at the next EVAL.
REQ-026 Ticks in EVAL SHALL be ignored; ticks in SETTLE are consumed as described in REQ-022.
REQ-027 All outputs SHALL be registered, with no combinational path from an input to an output.

Reset
REQ-028 reset=1 SHALL force IDLE, tick counter=0, w_enable=0, clear=0, save=0, range=0, out_range=0 and busy=0 on the next edge.
REQ-029 reset SHALL override every state, including mid-GATE; any partial gate is discarded and save is not asserted.
REQ-030 After reset release, the first tick SHALL start a full cycle from CLR.

Verification
REQ-031 GATE_TICKS=1, auto_en=1, cnt_ovf=0, th_digit=5, ticks every 100 cycles -> clear pulse, w_enable high for one tick period, save pulse 2 cycles after the ending tick, range=0.
REQ-032 range=0, cnt_ovf=1 at EVAL -> range=1, no save, one settle tick, then a new gate; on the next EVAL with cnt_ovf=0 and th_digit=3 -> save, range stays 1.
REQ-033 range=1, cnt_ovf=0, th_digit=0 -> range returns to 0 without save; range=1 with cnt_ovf=1 -> out_range=1 with save.
REQ-034 auto_en=0, range_sw=1, cnt_ovf=1 -> range=1, out_range=1, save every gate, and SETTLE is never entered.
REQ-035 reset asserted mid-GATE (GATE_TICKS=3, after 2 ticks) -> all outputs 0 next cycle, no save, and a restart on the next tick.
REQ-036 Throughout every scenario, an assertion checks that save&clear, save&w_enable and clear&w_enable are never high together.
